// File: rtl/mxu_result_drain.sv
// mxu_result_drain
//   Captures the DIM x DIM signed result matrix of temporal_mxu on the rising edge of
//   mxu_out_valid into a private buffer, then streams it row-major, one element per
//   beat, over a valid/ready interface. The array is free again as soon as the
//   capture cycle completes.
//
//   Optional feature macro: DRAIN_SATURATE_EN
//     defined   -> each streamed element is clamped to SAT_W signed bits
//                  (sign-extended to OUT_W); m_sat flags clamped beats.
//     undefined -> raw elements are streamed; m_sat is constant 0.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   mxu_out_valid       array result-valid level (capture on its rising edge)
//   mxu_out             packed matrix, element (r,c) at ((r*DIM+c)*OUT_W) +: OUT_W
//   m_valid/m_ready     stream handshake
//   m_data              stream element
//   m_row, m_col        indices of m_data
//   m_last              final element (DIM-1,DIM-1)
//   m_sat               element was clamped
//   busy                draining
//   overflow            sticky: a capture arrived mid-drain and was dropped
//   clear_overflow      synchronous clear of overflow (a coincident drop wins)
module mxu_result_drain #(
   parameter int unsigned DIM       = 2,
   parameter int unsigned BIT_WIDTH = 4,
   parameter int unsigned OUT_W     = 2 * BIT_WIDTH,
   parameter int unsigned SAT_W     = BIT_WIDTH + 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     mxu_out_valid,
   input  logic [DIM*DIM*OUT_W-1:0] mxu_out,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [OUT_W-1:0]         m_data,
   output logic [$clog2(DIM):0]     m_row,
   output logic [$clog2(DIM):0]     m_col,
   output logic                     m_last,
   output logic                     m_sat,
   output logic                     busy,
   output logic                     overflow,
   input  logic                     clear_overflow
);

   localparam int unsigned NumElem = DIM * DIM;
   localparam int unsigned IdxW    = $clog2(NumElem + 1);
   localparam int unsigned RcW     = $clog2(DIM) + 1;

   // The clamp must fit inside the element width.
   if (SAT_W < 2 || SAT_W > OUT_W) begin : g_sat_w_check
      $error("SAT_W must lie in [2, OUT_W]");
   end

   typedef enum logic [0:0] {StIdle, StDrain} state_e;

   state_e                   state_q, state_d;
   logic [IdxW-1:0]          idx_q, idx_d;
   logic [NumElem*OUT_W-1:0] buf_q, buf_d;
   logic                     prev_valid_q;
   logic                     overflow_q, overflow_d;

   logic                     cap_evt;
   logic                     is_last;
   logic                     xfer;
   logic [OUT_W-1:0]         elem;
   logic [OUT_W-1:0]         out_elem;
   logic                     out_sat;

   assign cap_evt = mxu_out_valid & ~prev_valid_q;
   assign is_last = (idx_q == IdxW'(NumElem - 1));
   assign xfer    = m_valid & m_ready;
   assign elem    = buf_q[idx_q*OUT_W +: OUT_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         buf_q        <= '0;
         prev_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         buf_q        <= buf_d;
         prev_valid_q <= mxu_out_valid;
         overflow_q   <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      buf_d      = buf_q;
      overflow_d = overflow_q;
      m_valid    = 1'b0;
      busy       = 1'b0;
      m_last     = 1'b0;
      if (clear_overflow) begin
         overflow_d = 1'b0;
      end
      unique case (state_q)
         StIdle: begin
            if (cap_evt) begin
               buf_d   = mxu_out;
               idx_d   = '0;
               state_d = StDrain;
            end
         end
         StDrain: begin
            m_valid = 1'b1;
            busy    = 1'b1;
            m_last  = is_last;
            if (xfer && is_last) begin
               idx_d = '0;
               // A capture on the final beat chains straight into the next drain.
               if (cap_evt) begin
                  buf_d = mxu_out;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               if (xfer) begin
                  idx_d = idx_q + IdxW'(1);
               end
               // Drop wins over a coincident clear.
               if (cap_evt) begin
                  overflow_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef DRAIN_SATURATE_EN
   localparam int SatMax = (2 ** (SAT_W - 1)) - 1;
   localparam int SatMin = -(2 ** (SAT_W - 1));

   always_comb begin
      out_elem = elem;
      out_sat  = 1'b0;
      if ($signed(elem) > SatMax) begin
         out_elem = OUT_W'(SatMax);
         out_sat  = 1'b1;
      end else if ($signed(elem) < SatMin) begin
         out_elem = OUT_W'(SatMin);
         out_sat  = 1'b1;
      end
   end
`else
   assign out_elem = elem;
   assign out_sat  = 1'b0;
`endif

   // Data-path outputs read as zero whenever nothing is being offered.
   assign m_data   = m_valid ? out_elem : '0;
   assign m_sat    = m_valid & out_sat;
   assign m_row    = m_valid ? RcW'(idx_q / DIM) : '0;
   assign m_col    = m_valid ? RcW'(idx_q % DIM) : '0;
   assign overflow = overflow_q;

endmodule
